alu_issue_ctrl: RTL and testbench

//   Upstream issue stage for the combinational 5-bit ALU (Al_unit). Holds a small operand

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_regfile.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the ALU issue stage.
package alu_pkg;

  localparam int unsigned DW   = 5;              // data width of A, B, Alu, rf entries
  localparam int unsigned SW   = 4;              // ALU select width, opaque here
  localparam int unsigned NREG = 8;              // register-file entries
  localparam int unsigned AW   = $clog2(NREG);   // register address width
  localparam int unsigned CW   = 8;              // completed-op counter width

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW operand register file: two async read ports, one write port, async clear.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] rf_q [NREG];

  // Storage: cleared on reset, single write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign rdata_a = rf_q[raddr_a];
  assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for an external combinational ALU: reads operands, drives S/A/B for one
// cycle, captures the result and hands it downstream over valid/ready.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_op,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wb,
  output logic [SW-1:0] S,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  input  logic [DW-1:0] Alu,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_rd,
  output logic [CW-1:0] op_count
);

  state_e        state_q, state_d;
  logic          accept, handoff;
  logic [SW-1:0] s_q;
  logic [DW-1:0] a_q, b_q;
  logic [AW-1:0] rd_q;
  logic          wb_q;
  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_rd_q;
  logic          out_valid_q;
  logic [CW-1:0] op_count_q;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rd_a, rd_b;
  logic [DW-1:0] a_fwd, b_fwd;

  alu_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (in_ra),
    .raddr_b (in_rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake strobes.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    handoff  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          handoff = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port mux: host preload only in IDLE, write-back only in EXEC, so never both.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state_q == IDLE && wr_en) begin
      rf_we = 1'b1;
    end else if (state_q == EXEC && wb_q) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = Alu;
    end
  end

  // A preload landing on the accept edge is forwarded into the operands.
  assign a_fwd = (state_q == IDLE && wr_en && wr_addr == in_ra) ? wr_data : rd_a;
  assign b_fwd = (state_q == IDLE && wr_en && wr_addr == in_rb) ? wr_data : rd_b;

  // Datapath: operand issue, result capture, handoff counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        s_q  <= in_op;
        a_q  <= a_fwd;
        b_q  <= b_fwd;
        rd_q <= in_rd;
        wb_q <= in_wb;
      end
      if (state_q == EXEC) begin
        out_data_q  <= Alu;
        out_rd_q    <= rd_q;
        out_valid_q <= 1'b1;
      end
      if (handoff) begin
        out_valid_q <= 1'b0;
        op_count_q  <= op_count_q + CW'(1);
      end
    end
  end

  assign S         = s_q;
  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an adder stub standing in for the ALU.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_ra, in_rb, in_rd;
  logic       in_wb;
  logic [3:0] S;
  logic [4:0] A, B, Alu;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [2:0] out_rd;
  logic [7:0] op_count;
  logic [5:0] sum;

  always #5 clk = ~clk;

  // ALU stub: (A + B) mod 32
  assign sum = {1'b0, A} + {1'b0, B};
  assign Alu = sum[4:0];

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rd     (in_rd),
    .in_wb     (in_wb),
    .S         (S),
    .A         (A),
    .B         (B),
    .Alu       (Alu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .op_count  (op_count)
  );

  typedef struct {
    logic [3:0] op;
    logic [2:0] ra, rb, rd;
    logic       wb;
    logic [4:0] exp_a, exp_b, exp_data;
  } vec_t;

  typedef struct {
    logic [4:0] data;
    logic [2:0] rd;
  } res_t;

  vec_t       tbl [5];
  res_t       sb [$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    res_t r;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got output with empty scoreboard expected none", name);
    end else begin
      r = sb.pop_front();
      check({name, "_data"}, 32'(out_data), 32'(r.data));
      check({name, "_rd"}, 32'(out_rd), 32'(r.rd));
    end
  endtask

  task automatic preload(input logic [2:0] addr, input logic [4:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one op, check EXEC-phase operands, result, optional stall, then handoff.
  task automatic do_op(input vec_t v, input int stall);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = v.op;
    in_ra    = v.ra;
    in_rb    = v.rb;
    in_rd    = v.rd;
    in_wb    = v.wb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{v.exp_data, v.rd});
    check("exec_S", 32'(S), 32'(v.op));
    check("exec_A", 32'(A), 32'(v.exp_a));
    check("exec_B", 32'(B), 32'(v.exp_b));
    check("exec_in_ready", 32'(in_ready), 32'd0);
    check("exec_out_valid", 32'(out_valid), 32'd0);
    out_ready = (stall == 0);
    @(posedge clk); #1;
    check("done_out_valid", 32'(out_valid), 32'd1);
    pop_check("result");
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'(v.exp_data));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_S", 32'(S), 32'(v.op));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_op_count", 32'(op_count), 32'(exp_count));
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("idle_A_hold", 32'(A), 32'(v.exp_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   accepts;

    // r1=21, r2=12; results hand-derived with (A+B) mod 32
    tbl[0] = '{4'hD, 3'd1, 3'd2, 3'd3, 1'b1, 5'd21, 5'd12, 5'd1};   // rf3 = 1
    tbl[1] = '{4'h2, 3'd3, 3'd1, 3'd5, 1'b1, 5'd1,  5'd21, 5'd22};  // rf5 = 22
    tbl[2] = '{4'h7, 3'd5, 3'd5, 3'd6, 1'b0, 5'd22, 5'd22, 5'd12};  // rf6 stays 0
    tbl[3] = '{4'h0, 3'd6, 3'd2, 3'd0, 1'b1, 5'd0,  5'd12, 5'd12};  // rf0 = 12
    tbl[4] = '{4'hF, 3'd0, 3'd5, 3'd7, 1'b0, 5'd12, 5'd22, 5'd2};

    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_ra     = '0;
    in_rb     = '0;
    in_rd     = '0;
    in_wb     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_A", 32'(A), 32'd0);
    check("rst_B", 32'(B), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(3'd1, 5'b10101);
    preload(3'd2, 5'b01100);

    // Table-driven ops, including write-back chains
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i], 0);
    end

    // Backpressure: five stalled cycles in DONE
    v = '{4'h9, 3'd1, 3'd2, 3'd3, 1'b1, 5'd21, 5'd12, 5'd1};
    do_op(v, 5);

    // Back-to-back requests with in_valid held high
    in_valid  = 1'b1;
    in_op     = 4'h5;
    in_ra     = 3'd1;
    in_rb     = 3'd2;
    in_rd     = 3'd7;
    in_wb     = 1'b0;
    out_ready = 1'b1;
    accepts   = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      check("b2b_in_ready", 32'(in_ready), 32'((cyc % 3) == 0));
      if (in_ready) begin
        accepts++;
        sb.push_back('{5'd1, 3'd7});
      end
      if (out_valid) pop_check("b2b_result");
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    exp_count = exp_count + 8'd3;
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_op_count", 32'(op_count), 32'(exp_count));

    // Bypass: preload to r4 on the accept edge feeds both operands
    wr_en    = 1'b1;
    wr_addr  = 3'd4;
    wr_data  = 5'b00111;
    in_valid = 1'b1;
    in_op    = 4'h3;
    in_ra    = 3'd4;
    in_rb    = 3'd4;
    in_rd    = 3'd1;
    in_wb    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{5'b01110, 3'd1});
    check("byp_A", 32'(A), 32'd7);
    check("byp_B", 32'(B), 32'd7);
    // Preload attempt during EXEC must be dropped
    wr_data = 5'd31;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("byp_out_valid", 32'(out_valid), 32'd1);
    pop_check("byp_result");
    @(posedge clk); #1;
    exp_count++;
    check("byp_op_count", 32'(op_count), 32'(exp_count));
    // r4 must hold 7 (not 31): 7 + r1(21) = 28
    v = '{4'h1, 3'd4, 3'd1, 3'd2, 1'b0, 5'd7, 5'd21, 5'd28};
    do_op(v, 0);

    // Reset during EXEC discards the op and its write-back
    in_valid = 1'b1;
    in_op    = 4'hA;
    in_ra    = 3'd1;
    in_rb    = 3'd4;
    in_rd    = 3'd2;
    in_wb    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_S", 32'(S), 32'hA);
    rst_n = 1'b0;
    #1;
    check("mid_rst_S", 32'(S), 32'd0);
    check("mid_rst_A", 32'(A), 32'd0);
    check("mid_rst_B", 32'(B), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    check("post_rst_out_valid2", 32'(out_valid), 32'd0);
    exp_count = '0;
    // Every entry must read 0 (none held 16 before, so 2x = 0 only if cleared)
    for (int i = 0; i < 8; i++) begin
      v = '{4'h4, 3'(i), 3'(i), 3'(i), 1'b0, 5'd0, 5'd0, 5'd0};
      do_op(v, 0);
    end

    // Counter wrap after 256 handoffs since reset
    while (exp_count != 8'd0) begin
      v = '{4'h6, 3'd0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0};
      do_op(v, 0);
    end
    check("wrap_op_count", 32'(op_count), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
